// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Shift-add multiply, restoring divide, sign fix-up, HI/LO registers.
module md_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q, mq_q, opd_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q, negr_q, isdiv_q, nowr_q;
   logic             busy_q, done_q;

   logic               sgn, xneg, yneg, ynz, last, dge;
   logic [WIDTH-1:0]   xabs, yabs, addend, diff;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic [WIDTH:0]     madd, dsh;
   logic [2*WIDTH-1:0] prod, prod_fix;

   always_comb begin
      sgn      = ~op[0];
      xneg     = sgn & X[WIDTH-1];
      yneg     = sgn & Y[WIDTH-1];
      xabs     = xneg ? -X : X;
      yabs     = yneg ? -Y : Y;
      ynz      = |Y;
      addend   = mq_q[0] ? opd_q : '0;
      madd     = {1'b0, acc_q} + {1'b0, addend};
      // Remainder after shift fits W+1 bits; a successful subtract fits W.
      dsh      = {acc_q, mq_q[WIDTH-1]};
      dge      = dsh >= {1'b0, opd_q};
      diff     = dsh[WIDTH-1:0] - opd_q;
      prod     = {acc_q, mq_q};
      prod_fix = neg_q ? -prod : prod;
      q_fix    = neg_q ? -mq_q : mq_q;
      r_fix    = negr_q ? -acc_q : acc_q;
      last     = cnt_q == CNT_W'(WIDTH - 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mq_q    <= '0;
         opd_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         isdiv_q <= 1'b0;
         nowr_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (start) begin
                     acc_q   <= '0;
                     cnt_q   <= '0;
                     opd_q   <= op[1] ? yabs : xabs;
                     mq_q    <= op[1] ? xabs : yabs;
                     neg_q   <= xneg ^ yneg;
                     negr_q  <= xneg;
                     isdiv_q <= op[1];
                     nowr_q  <= op[1] & ~ynz;
                     busy_q  <= 1'b1;
                     if (!op[1])   state_q <= MUL;
                     else if (ynz) state_q <= DIV;
                     else          state_q <= FIX;
                  end else begin
                     if (hi_we) hi_q <= wdata;
                     if (lo_we) lo_q <= wdata;
                  end
               end
               MUL: begin
                  acc_q <= madd[WIDTH:1];
                  mq_q  <= {madd[0], mq_q[WIDTH-1:1]};
                  cnt_q <= cnt_q + 1'b1;
                  if (last) state_q <= FIX;
               end
               DIV: begin
                  acc_q <= dge ? diff : dsh[WIDTH-1:0];
                  mq_q  <= {mq_q[WIDTH-2:0], dge};
                  cnt_q <= cnt_q + 1'b1;
                  if (last) state_q <= FIX;
               end
               FIX: begin
                  if (!nowr_q) begin
                     hi_q <= isdiv_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= isdiv_q ? q_fix : prod_fix[WIDTH-1:0];
                  end
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: products, quotients, latency,
// cancel, reset mid-operation and HI/LO write rules.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, cancel, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] X, Y, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;
   int cyc, bc, dcnt;

   md_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .X(X), .Y(Y), .cancel(cancel), .hi_we(hi_we),
      .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      start = 1'b1; op = o; X = a; Y = b;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int c, output int b);
      c = 1;
      b = busy ? 1 : 0;
      while (!done && c < 200) begin
         step();
         c++;
         if (busy) b++;
      end
   endtask

   task automatic run(input string tag, input logic [1:0] o,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo);
      launch(o, a, b);
      wait_done(cyc, bc);
      chk({tag, ".lat"}, 32'(cyc), 32'd34);
      chk({tag, ".hi"}, hi, ehi);
      chk({tag, ".lo"}, lo, elo);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cancel = 1'b0;
      hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
      X = '0; Y = '0; wdata = '0;
      #1;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.hi", hi, 32'h0);
      chk("rst.lo", lo, 32'h0);
      #11 rst_n = 1'b1;
      step();

      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, bc);
      chk("multu.lat", 32'(cyc), 32'd34);
      chk("multu.busycyc", 32'(bc), 32'd33);
      chk("multu.busy_at_done", 32'(busy), 32'd0);
      chk("multu.hi", hi, 32'hFFFF_FFFE);
      chk("multu.lo", lo, 32'h0000_0001);
      step();
      chk("multu.done1", 32'(done), 32'd0);

      run("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,
          32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'h0);
      run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 32'h8000_0000);

      hi_we = 1'b1; wdata = 32'h1234;
      step();
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
      step();
      lo_we = 1'b0;
      chk("mthi", hi, 32'h1234);
      chk("mtlo", lo, 32'h5678);

      launch(2'b11, 32'd55, 32'd0);
      wait_done(cyc, bc);
      chk("div0.lat", 32'(cyc), 32'd2);
      chk("div0.busycyc", 32'(bc), 32'd1);
      chk("div0.hi", hi, 32'h1234);
      chk("div0.lo", lo, 32'h5678);

      launch(2'b01, 32'd5, 32'd6);
      for (int i = 0; i < 9; i++) step();
      chk("cancel.busy_before", 32'(busy), 32'd1);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("cancel.busy", 32'(busy), 32'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) dcnt++;
         step();
      end
      chk("cancel.nodone", 32'(dcnt), 32'd0);
      chk("cancel.hi", hi, 32'h1234);
      chk("cancel.lo", lo, 32'h5678);
      run("after_cancel", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

      start = 1'b1; op = 2'b11; X = 32'd1; Y = 32'd0;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      step();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      wait_done(cyc, bc);
      chk("start_we.hi", hi, 32'h0);
      chk("start_we.lo", lo, 32'd30);

      launch(2'b01, 32'd3, 32'd4);
      for (int i = 0; i < 4; i++) step();
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF;
      step();
      hi_we = 1'b0; lo_we = 1'b0;
      chk("busy_we.hi", hi, 32'h0);
      chk("busy_we.lo", lo, 32'd30);
      wait_done(cyc, bc);
      chk("busy_we.rhi", hi, 32'h0);
      chk("busy_we.rlo", lo, 32'd12);

      launch(2'b11, 32'd100, 32'd7);
      for (int i = 0; i < 19; i++) step();
      chk("rstmid.busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid.busy", 32'(busy), 32'd0);
      chk("rstmid.hi", hi, 32'h0);
      chk("rstmid.lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run("after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Operand X comes from the forwarded rs value. Operand Y is the output of the EX-stage Y operand selector.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Its busy output drives the hazard unit to stall MF*/MT*/MD instructions while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch operation selected by op; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- X  input  WIDTH  first operand: multiplicand or dividend.
- Y  input  WIDTH  second operand: multiplier or divisor, from the Y operand selector.
- cancel  input  1  pipeline flush; aborts an in-flight operation.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO just updated by an MD operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi, lo, internal accumulators and counter all 0; busy=0; done=0. Reset mid-operation discards all progress.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, cancel=0:
  - Capture |X| and |Y| into the unsigned datapath. Absolute value applies only for MULT/DIV; unsigned ops pass raw values.
  - Record the result-sign flags.
  - Counter=0; go to MUL (op[1]=0) or DIV (op[1]=1).
  - busy=1 from the following cycle.
- DIV with Y==0: go straight to FIX with a no-write flag set. HI/LO are unchanged; done still pulses.
- MUL: shift-add, one multiplier bit per cycle, 64-bit {acc,mq} product. WIDTH cycles, then FIX.
- DIV: restoring shift-subtract, one quotient bit per cycle. WIDTH cycles, then FIX.
- FIX (1 cycle):
  - Apply signs. MULT: negate the 64-bit product if X and Y signs differ. DIV: negate quotient if signs differ; remainder takes the sign of X.
  - Write hi (product upper / remainder) and lo (product lower / quotient).
  - Next state IDLE; busy=0 and done=1 in the following cycle.
- Latency: start sampled at edge E0; busy high after E0 through E(WIDTH+1); HI/LO valid and done=1 after E(WIDTH+1). That is 34 cycles for WIDTH=32; divide-by-zero takes 2 cycles.
- done is high for exactly one cycle and never coincides with busy=1.
- Edge cases:
  - 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the unsigned core; no special casing.
  - MULT 0x80000000 x 0x80000000: hi=0x40000000, lo=0.
- start while busy: ignored.
- cancel: any state returns to IDLE next edge; busy=0, done=0, HI/LO unchanged. Takes priority over start in the same cycle.
- hi_we/lo_we:
  - Honoured only when state==IDLE and start=0; hi/lo=wdata next edge.
  - While busy, or when coincident with start, the write is dropped; the hazard unit guarantees this does not happen in legal flow.
  - Both enables may be set together.
- hi/lo outputs are direct register values with no bypass from wdata.

Test Plan:
- MULTU X=0xFFFFFFFF, Y=0xFFFFFFFF -> busy 33 cycles, done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT X=0xFFFFFFFD (-3), Y=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV X=0xFFFFFFF9 (-7), Y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU X=100, Y=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU Y=0 with hi=0x1234, lo=0x5678 preloaded via hi_we/lo_we -> done after 2 cycles; hi/lo unchanged.
- Start MULTU 5x6; assert cancel at cycle 10 -> busy drops next cycle, no done, hi/lo keep prior values. A new start afterwards completes normally.
- Assert rst_n=0 mid-DIV at cycle 20 -> immediately busy=0, hi=lo=0. Also: start and hi_we in the same cycle -> only the MD result is written; hi_we while busy -> ignored.
